// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the input debouncer: counter sizing and legal parameter limits.
package input_debouncer_pkg;

  localparam int TICK_DIV_MIN     = 1;
  localparam int STABLE_TICKS_MIN = 1;

  // Width needed to hold 0..stable_ticks without overflow.
  function automatic int cnt_width(input int stable_ticks);
    return $clog2(stable_ticks + 1);
  endfunction

endpackage

// File: rtl/input_debouncer_channel.sv
// One debounce channel: 2-flop synchronizer, tick-based stability counter,
// debounced level register and registered rise/fall pulses.
module debounce_channel
  import input_debouncer_pkg::*;
#(
  parameter int   STABLE_TICKS = 10,
  parameter logic RESET_BIT    = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_raw,
  input  logic i_tick,
  output logic o_deb,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_deb;
  logic          r_rise;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  // Sync stages reset to the output level so reset release shows no mismatch.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1 <= RESET_BIT;
      r_sync2 <= RESET_BIT;
      r_deb   <= RESET_BIT;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (i_tick) begin
        if (r_cnt == CNT_LAST) begin
          r_deb  <= r_sync2;
          r_cnt  <= '0;
          r_rise <= r_sync2;
          r_fall <= ~r_sync2;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign o_deb  = r_deb;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/input_debouncer.sv
// Multi-channel input debouncer: shared sample-tick prescaler feeding
// WIDTH independent debounce channels.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int               WIDTH        = 10,
  parameter int               TICK_DIV     = 50000,
  parameter int               STABLE_TICKS = 10,
  parameter logic [WIDTH-1:0] RESET_VALUE  = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] deb_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  if (TICK_DIV < TICK_DIV_MIN) begin : g_bad_tick_div
    $error("input_debouncer: TICK_DIV must be at least %0d", TICK_DIV_MIN);
  end
  if (STABLE_TICKS < STABLE_TICKS_MIN) begin : g_bad_stable_ticks
    $error("input_debouncer: STABLE_TICKS must be at least %0d", STABLE_TICKS_MIN);
  end

  // TICK_DIV of 1 needs a 1-bit counter that simply stays at zero.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_presc;
  logic          w_tick;

  assign w_tick = (r_presc == PRESC_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .RESET_BIT    (RESET_VALUE[g])
    ) u_ch (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .i_raw     (raw_in[g]),
      .i_tick    (w_tick),
      .o_deb     (deb_out[g]),
      .o_rise    (rise_pulse[g]),
      .o_fall    (fall_pulse[g])
    );
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer with a behavioural per-cycle reference model.
module tb_input_debouncer;

  localparam int W  = 4;
  localparam int TD = 4;
  localparam int ST = 3;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] raw_in;
  logic [W-1:0] deb_out;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;

  int total = 0;
  int bad   = 0;

  // reference model state
  int           m_phase;
  int           m_ticks [W];
  logic [W-1:0] m_s1, m_s2, m_deb, m_rise, m_fall;

  input_debouncer #(
    .WIDTH        (W),
    .TICK_DIV     (TD),
    .STABLE_TICKS (ST),
    .RESET_VALUE  (4'b0000)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .raw_in     (raw_in),
    .deb_out    (deb_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_phase = 0;
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_rise = '0; m_fall = '0;
    for (int i = 0; i < W; i++) m_ticks[i] = 0;
  endtask

  // Advance one clock: model the sample tick as every TD-th cycle since reset,
  // a channel accepts after ST ticks of uninterrupted disagreement.
  task automatic step();
    bit tick;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      tick = (m_phase % TD) == TD - 1;
      m_phase = m_phase + 1;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] == m_deb[i]) m_ticks[i] = 0;
        else if (tick) begin
          m_ticks[i] = m_ticks[i] + 1;
          if (m_ticks[i] == ST) begin
            m_deb[i] = m_s2[i];
            m_ticks[i] = 0;
            if (m_s2[i]) m_rise[i] = 1'b1;
            else         m_fall[i] = 1'b1;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = raw_in;
    end
    #1;
  endtask

  task automatic do_reset(input logic [W-1:0] val);
    reset_n = 1'b0;
    raw_in  = val;
    model_reset();
    repeat (3) step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    int first = -1;
    int rises = 0;
    reset_n = 1'b0;
    raw_in  = 4'b1111;
    model_reset();
    repeat (3) step();
    total++;
    if (deb_out !== 4'b0000 || rise_pulse !== 4'b0000 || fall_pulse !== 4'b0000) begin
      bad++;
      $display("FAIL reset_values deb=%b rise=%b fall=%b expected all 0000", deb_out, rise_pulse, fall_pulse);
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      total++;
      if (deb_out !== m_deb || rise_pulse !== m_rise || fall_pulse !== m_fall) begin
        bad++;
        $display("FAIL reset_model k=%0d deb=%b/%b rise=%b/%b fall=%b/%b", k, deb_out, m_deb, rise_pulse, m_rise, fall_pulse, m_fall);
      end
      if (first < 0 && deb_out === 4'b1111) first = k;
      if (rise_pulse !== 4'b0000) rises++;
    end
    total++;
    if (first < 11 || first > 14) begin
      bad++;
      $display("FAIL reset_latency got=%0d expected 11..14", first);
    end
    total++;
    if (rises != 1) begin
      bad++;
      $display("FAIL reset_rise_count got=%0d expected 1", rises);
    end
  endtask

  task automatic test_glitch();
    int events = 0;
    do_reset(4'b0000);
    raw_in[0] = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      if (k == 7) raw_in[0] = 1'b0;
      step();
      total++;
      if (deb_out !== m_deb || rise_pulse !== m_rise || fall_pulse !== m_fall) begin
        bad++;
        $display("FAIL glitch_model k=%0d deb=%b/%b rise=%b/%b fall=%b/%b", k, deb_out, m_deb, rise_pulse, m_rise, fall_pulse, m_fall);
      end
      if (deb_out[0] !== 1'b0 || rise_pulse[0] !== 1'b0 || fall_pulse[0] !== 1'b0) events++;
    end
    total++;
    if (events != 0) begin
      bad++;
      $display("FAIL glitch_reject got=%0d output events expected 0", events);
    end
  endtask

  task automatic test_press();
    for (int dir = 1; dir >= 0; dir--) begin
      int first = -1;
      int pulses = 0;
      if (dir == 1) do_reset(4'b0000);
      raw_in[1] = dir[0];
      for (int k = 1; k <= 20; k++) begin
        step();
        total++;
        if (deb_out !== m_deb || rise_pulse !== m_rise || fall_pulse !== m_fall) begin
          bad++;
          $display("FAIL press_model dir=%0d k=%0d deb=%b/%b rise=%b/%b fall=%b/%b", dir, k, deb_out, m_deb, rise_pulse, m_rise, fall_pulse, m_fall);
        end
        if (first < 0 && deb_out[1] === dir[0]) first = k;
        if ((dir == 1 ? rise_pulse[1] : fall_pulse[1]) === 1'b1) pulses++;
      end
      total++;
      if (first < 11 || first > 14) begin
        bad++;
        $display("FAIL press_latency dir=%0d got=%0d expected 11..14", dir, first);
      end
      total++;
      if (pulses != 1) begin
        bad++;
        $display("FAIL press_pulse_count dir=%0d got=%0d expected 1", dir, pulses);
      end
    end
  endtask

  task automatic test_bounce();
    logic lvl = 1'b0;
    int   moved = 0;
    int   first = -1;
    int   rises = 0;
    do_reset(4'b0000);
    for (int c = 0; c < 30; c++) begin
      if (c % 3 == 0) lvl = ~lvl;
      raw_in[2] = lvl;
      step();
      total++;
      if (deb_out !== m_deb || rise_pulse !== m_rise || fall_pulse !== m_fall) begin
        bad++;
        $display("FAIL bounce_model c=%0d deb=%b/%b rise=%b/%b", c, deb_out, m_deb, rise_pulse, m_rise);
      end
      if (deb_out[2] !== 1'b0 || rise_pulse[2] !== 1'b0) moved++;
    end
    total++;
    if (moved != 0) begin
      bad++;
      $display("FAIL bounce_hold got=%0d changes expected 0", moved);
    end
    raw_in[2] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (first < 0 && deb_out[2] === 1'b1) first = k;
      if (rise_pulse[2] === 1'b1) rises++;
    end
    total++;
    if (first < 11 || first > 14) begin
      bad++;
      $display("FAIL bounce_settle got=%0d expected 11..14", first);
    end
    total++;
    if (rises != 1) begin
      bad++;
      $display("FAIL bounce_rise_count got=%0d expected 1", rises);
    end
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] seen_deb  = '0;
    logic [W-1:0] seen_rise = '0;
    do_reset(4'b0000);
    raw_in = 4'b1010;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (seen_deb == '0 && deb_out !== 4'b0000) begin
        seen_deb  = deb_out;
        seen_rise = rise_pulse;
      end
    end
    total++;
    if (seen_deb !== 4'b1010 || seen_rise !== 4'b1010) begin
      bad++;
      $display("FAIL simultaneous deb=%b rise=%b expected 1010/1010", seen_deb, seen_rise);
    end
  endtask

  task automatic test_reset_mid();
    int first = -1;
    logic [W-1:0] rise_at = '0;
    do_reset(4'b0000);
    raw_in = 4'b0110;
    repeat (20) step();
    total++;
    if (deb_out !== 4'b0110) begin
      bad++;
      $display("FAIL reset_mid_setup got=%b expected 0110", deb_out);
    end
    raw_in = 4'b1001;
    repeat (8) step();
    reset_n = 1'b0;
    #1;
    total++;
    if (deb_out !== 4'b0000 || rise_pulse !== 4'b0000 || fall_pulse !== 4'b0000) begin
      bad++;
      $display("FAIL reset_mid_async deb=%b rise=%b fall=%b expected 0000", deb_out, rise_pulse, fall_pulse);
    end
    model_reset();
    repeat (2) step();
    reset_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      total++;
      if (deb_out !== m_deb || rise_pulse !== m_rise || fall_pulse !== m_fall) begin
        bad++;
        $display("FAIL reset_mid_model k=%0d deb=%b/%b rise=%b/%b", k, deb_out, m_deb, rise_pulse, m_rise);
      end
      if (first < 0 && deb_out === 4'b1001) begin
        first = k;
        rise_at = rise_pulse;
      end
    end
    total++;
    if (first < 11 || first > 14 || rise_at !== 4'b1001) begin
      bad++;
      $display("FAIL reset_mid_latency got=%0d rise=%b expected 11..14 and 1001", first, rise_at);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset(4'b0000);
    for (int n = 0; n < 80; n++) begin
      int hold = $urandom_range(1, 18);
      raw_in = raw_in ^ W'($urandom_range(0, 15));
      for (int h = 0; h < hold; h++) begin
        step();
        if (deb_out !== m_deb || rise_pulse !== m_rise || fall_pulse !== m_fall) begin
          errs++;
          if (errs <= 5)
            $display("FAIL random_model n=%0d deb=%b/%b rise=%b/%b fall=%b/%b", n, deb_out, m_deb, rise_pulse, m_rise, fall_pulse, m_fall);
        end
        if ((rise_pulse & fall_pulse) !== 4'b0000) begin
          errs++;
          if (errs <= 5)
            $display("FAIL random_both_pulses rise=%b fall=%b expected no overlap", rise_pulse, fall_pulse);
        end
      end
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL random_summary got=%0d mismatching cycles expected 0", errs);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    raw_in  = '0;
    model_reset();
    test_reset();
    test_glitch();
    test_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
